// File: rtl/rfsoc_config.sv
// ============================================================================
//  Module      : rfsoc_config (package)
//  Description : Shared definitions for the PL-side DAC playback logic:
//                sequencer state type, DAC channel count and the default
//                widths used by dac_playback_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rfsoc_config;

  // Number of DAC driver channels on this board.
  localparam int NUM_DAC_CHANNELS       = 16;

  // Default widths for the playback sequencer.
  localparam int DEFAULT_DELAY_WIDTH    = 16;
  localparam int DEFAULT_REPEAT_WIDTH   = 16;
  localparam int DEFAULT_GAP_WIDTH      = 16;
  localparam int DEFAULT_TIMEOUT_CYCLES = 65535;

  // Playback sequencer states.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARM  = 3'd1,
    RUN  = 3'd2,
    GAP  = 3'd3,
    DONE = 3'd4
  } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/seq_delay_table.sv
// ============================================================================
//  Module      : seq_delay_table
//  Description : Per-channel start-delay register file. One write port,
//                every entry exposed in parallel so the sequencer can compare
//                all channels against its run counter in the same cycle.
//  Ports       : pl_clk      - clock
//                rst         - asynchronous active-high reset (table -> 0)
//                we          - write strobe (already qualified by caller)
//                addr        - entry to write
//                wdata       - delay value to write
//                delays_flat - all entries, entry i at [i*DELAY_WIDTH +: DELAY_WIDTH]
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_delay_table
  import rfsoc_config::*;
#(
  parameter int NUM_CHANNELS = NUM_DAC_CHANNELS,
  parameter int DELAY_WIDTH  = DEFAULT_DELAY_WIDTH,
  parameter int ADDR_WIDTH   = $clog2(NUM_CHANNELS)
) (
  input  logic                                pl_clk,
  input  logic                                rst,
  input  logic                                we,
  input  logic [ADDR_WIDTH-1:0]               addr,
  input  logic [DELAY_WIDTH-1:0]              wdata,
  output logic [NUM_CHANNELS*DELAY_WIDTH-1:0] delays_flat
);

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_entry
    logic [DELAY_WIDTH-1:0] entry;

    always_ff @(posedge pl_clk or posedge rst) begin
      if (rst) begin
        entry <= '0;
      end else if (we && (addr == ADDR_WIDTH'(i))) begin
        entry <= wdata;
      end
    end

    assign delays_flat[i*DELAY_WIDTH +: DELAY_WIDTH] = entry;
  end

endmodule

`default_nettype wire

// File: rtl/dac_playback_sequencer.sv
// ============================================================================
//  Module      : dac_playback_sequencer
//  Description : Issues one-cycle start pulses to the enabled DAC channels,
//                each after its programmed delay from a trigger rising edge,
//                waits for all started channels to report done, inserts an
//                inter-repeat gap and repeats for a programmed count
//                (0 = continuous until abort).
//  Ports       : pl_clk, rst         - clock, async active-high reset
//                cfg_we/addr/delay   - delay table write (ignored while busy)
//                channel_enable      - participating channels (latched in ARM)
//                repeat_count        - repetitions, 0 = continuous
//                gap_cycles          - idle cycles between repetitions
//                trigger             - level; rising edge starts a sequence
//                abort               - level; returns to IDLE next cycle
//                chan_done           - per-channel completion pulses
//                chan_start          - registered one-cycle start pulses
//                busy                - state != IDLE
//                seq_done            - one-cycle pulse at normal completion
//                repeat_index        - current repetition, 0-based
//                timeout_err         - sticky watchdog flag
//  Options     : SEQ_TIMEOUT_EN - enables the RUN-state completion watchdog;
//                when undefined timeout_err is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dac_playback_sequencer
  import rfsoc_config::*;
#(
  parameter int NUM_CHANNELS   = NUM_DAC_CHANNELS,
  parameter int DELAY_WIDTH    = DEFAULT_DELAY_WIDTH,
  parameter int REPEAT_WIDTH   = DEFAULT_REPEAT_WIDTH,
  parameter int GAP_WIDTH      = DEFAULT_GAP_WIDTH,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                            pl_clk,
  input  logic                            rst,
  input  logic                            cfg_we,
  input  logic [$clog2(NUM_CHANNELS)-1:0] cfg_addr,
  input  logic [DELAY_WIDTH-1:0]          cfg_delay,
  input  logic [NUM_CHANNELS-1:0]         channel_enable,
  input  logic [REPEAT_WIDTH-1:0]         repeat_count,
  input  logic [GAP_WIDTH-1:0]            gap_cycles,
  input  logic                            trigger,
  input  logic                            abort,
  input  logic [NUM_CHANNELS-1:0]         chan_done,
  output logic [NUM_CHANNELS-1:0]         chan_start,
  output logic                            busy,
  output logic                            seq_done,
  output logic [REPEAT_WIDTH-1:0]         repeat_index,
  output logic                            timeout_err
);

  localparam int ADDR_WIDTH = $clog2(NUM_CHANNELS);
  localparam logic [DELAY_WIDTH-1:0] CNT_MAX = '1;

  seq_state_t state, state_next;

  logic                            trigger_q;
  logic                            trig_edge;
  logic                            accept;
  logic                            restart;
  logic                            run_complete;
  logic                            last_rep;
  logic                            gap_end;
  logic                            wd_expire;

  logic [NUM_CHANNELS-1:0]         en_mask;
  logic [NUM_CHANNELS-1:0]         fired;
  logic [NUM_CHANNELS-1:0]         pending;
  logic [NUM_CHANNELS-1:0]         fire;
  logic [REPEAT_WIDTH-1:0]         repeat_lat;
  logic [GAP_WIDTH-1:0]            gap_lat;
  logic [GAP_WIDTH-1:0]            gap_cnt;
  logic [DELAY_WIDTH-1:0]          run_cnt;
  logic [NUM_CHANNELS*DELAY_WIDTH-1:0] delays_flat;

  // --------------------------------------------------------------------------
  // Delay table: writes are only honoured while the sequencer is idle so a
  // running sequence always sees a stable table.
  // --------------------------------------------------------------------------
  seq_delay_table #(
    .NUM_CHANNELS (NUM_CHANNELS),
    .DELAY_WIDTH  (DELAY_WIDTH),
    .ADDR_WIDTH   (ADDR_WIDTH)
  ) u_delay_table (
    .pl_clk      (pl_clk),
    .rst         (rst),
    .we          (cfg_we && (state == IDLE)),
    .addr        (cfg_addr),
    .wdata       (cfg_delay),
    .delays_flat (delays_flat)
  );

  assign trig_edge    = trigger & ~trigger_q;
  // abort wins over a simultaneous edge; an empty enable mask never starts.
  assign accept       = (state == IDLE) && trig_edge && (channel_enable != '0) && !abort;
  assign run_complete = (fired == en_mask) && (pending == '0);
  assign last_rep     = (repeat_lat != '0) && (repeat_index == repeat_lat - 1'b1);
  // gap_lat is never zero while in GAP; a zero gap bypasses the state.
  assign gap_end      = (state == GAP) && (gap_cnt == gap_lat - 1'b1);

  // Fire when the run counter reaches a channel's delay; fired[] keeps a
  // saturated counter from re-firing the same channel.
  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_fire
    assign fire[i] = (state == RUN) && en_mask[i] && !fired[i] &&
                     (run_cnt == delays_flat[i*DELAY_WIDTH +: DELAY_WIDTH]);
  end

  // --------------------------------------------------------------------------
  // Completion watchdog
  // --------------------------------------------------------------------------
`ifdef SEQ_TIMEOUT_EN
  localparam int WD_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_WIDTH-1:0] wd_cnt;
  logic                wd_active;
  logic                timeout_q;

  // Counting runs while something is still outstanding or the counter has
  // hit its ceiling (a channel whose delay can never be reached).
  assign wd_active = (state == RUN) && ((run_cnt == CNT_MAX) || (pending != '0));
  assign wd_expire = wd_active && (wd_cnt == WD_WIDTH'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge pl_clk or posedge rst) begin
    if (rst) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if ((state != RUN) || (fire != '0) || !wd_active) begin
        wd_cnt <= '0;
      end else begin
        wd_cnt <= wd_cnt + 1'b1;
      end

      if (wd_expire) begin
        timeout_q <= 1'b1;
      end else if (accept) begin
        timeout_q <= 1'b0;
      end
    end
  end

  assign timeout_err = timeout_q;
`else
  assign wd_expire   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // FSM next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    restart    = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          state_next = ARM;
        end
      end
      ARM: begin
        state_next = RUN;
      end
      RUN: begin
        if (wd_expire) begin
          state_next = IDLE;
        end else if (run_complete) begin
          if (last_rep) begin
            state_next = DONE;
          end else if (gap_lat == '0) begin
            state_next = RUN;
            restart    = 1'b1;
          end else begin
            state_next = GAP;
          end
        end
      end
      GAP: begin
        if (gap_end) begin
          state_next = RUN;
          restart    = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (abort) begin
      state_next = IDLE;
      restart    = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // State, counters and masks
  // --------------------------------------------------------------------------
  always_ff @(posedge pl_clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      trigger_q    <= 1'b0;
      chan_start   <= '0;
      en_mask      <= '0;
      fired        <= '0;
      pending      <= '0;
      repeat_lat   <= '0;
      repeat_index <= '0;
      gap_lat      <= '0;
      gap_cnt      <= '0;
      run_cnt      <= '0;
    end else begin
      state      <= state_next;
      trigger_q  <= trigger;
      chan_start <= abort ? '0 : fire;

      if (state == GAP) begin
        gap_cnt <= gap_cnt + 1'b1;
      end else begin
        gap_cnt <= '0;
      end

      if (state == ARM) begin
        en_mask      <= channel_enable;
        repeat_lat   <= repeat_count;
        gap_lat      <= gap_cycles;
        repeat_index <= '0;
        run_cnt      <= '0;
        fired        <= '0;
        pending      <= '0;
      end else if (restart) begin
        // Wraps naturally in continuous mode.
        repeat_index <= repeat_index + 1'b1;
        run_cnt      <= '0;
        fired        <= '0;
        pending      <= '0;
      end else if (state == RUN) begin
        if (run_cnt != CNT_MAX) begin
          run_cnt <= run_cnt + 1'b1;
        end
        fired   <= fired | fire;
        // A done arriving in the fire cycle finds pending still clear and
        // is dropped, as are dones from channels never started.
        pending <= (pending & ~chan_done) | fire;
      end
    end
  end

  assign busy     = (state != IDLE);
  assign seq_done = (state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_dac_playback_sequencer.sv
// ============================================================================
//  Module      : tb_dac_playback_sequencer
//  Description : Self-checking bench for dac_playback_sequencer. Expected
//                start/done/busy/index timelines are computed from the
//                sequencing rules per run; a responder returns chan_done a
//                fixed latency after each observed start.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dac_playback_sequencer;

  localparam int NCH = 16;
  localparam int DW  = 16;
  localparam int RW  = 16;
  localparam int GW  = 16;
  localparam int TO  = 100;

  logic           pl_clk = 1'b0;
  logic           rst;
  logic           cfg_we;
  logic [3:0]     cfg_addr;
  logic [DW-1:0]  cfg_delay;
  logic [NCH-1:0] channel_enable;
  logic [RW-1:0]  repeat_count;
  logic [GW-1:0]  gap_cycles;
  logic           trigger;
  logic           abort;
  logic [NCH-1:0] chan_done;
  logic [NCH-1:0] chan_start;
  logic           busy;
  logic           seq_done;
  logic [RW-1:0]  repeat_index;
  logic           timeout_err;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int model_delay [NCH];

  dac_playback_sequencer #(
    .NUM_CHANNELS   (NCH),
    .DELAY_WIDTH    (DW),
    .REPEAT_WIDTH   (RW),
    .GAP_WIDTH      (GW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .pl_clk         (pl_clk),
    .rst            (rst),
    .cfg_we         (cfg_we),
    .cfg_addr       (cfg_addr),
    .cfg_delay      (cfg_delay),
    .channel_enable (channel_enable),
    .repeat_count   (repeat_count),
    .gap_cycles     (gap_cycles),
    .trigger        (trigger),
    .abort          (abort),
    .chan_done      (chan_done),
    .chan_start     (chan_start),
    .busy           (busy),
    .seq_done       (seq_done),
    .repeat_index   (repeat_index),
    .timeout_err    (timeout_err)
  );

  always #5 pl_clk = ~pl_clk;
  always @(posedge pl_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic write_entry(input int a, input int d);
    @(negedge pl_clk);
    cfg_we    = 1'b1;
    cfg_addr  = a[3:0];
    cfg_delay = d[DW-1:0];
    model_delay[a] = d;
    @(negedge pl_clk);
    cfg_we = 1'b0;
  endtask

  task automatic program_random(input int maxd);
    for (int i = 0; i < NCH; i++) write_entry(i, $urandom_range(0, maxd));
  endtask

  // One sequence: build the expected timeline from the rules, then run it
  // cycle by cycle with a done responder of latency lat (>= 1).
  task automatic run_seq(input logic [NCH-1:0] en, input int rep, input int gap,
                         input int lat, input int abort_after, input bit noise,
                         input bit retrig);
    logic [NCH-1:0] exp_start [int];
    int             rep_start [$];
    int             due [NCH];
    int             t0, r_cyc, c_cyc, s, nreps, dmax, dmin;
    int             done_cyc, abort_cyc, busy_end, idx;
    logic [NCH-1:0] exp_mask;

    dmax = 0;
    dmin = 1 << 30;
    for (int i = 0; i < NCH; i++) begin
      if (en[i]) begin
        if (model_delay[i] > dmax) dmax = model_delay[i];
        if (model_delay[i] < dmin) dmin = model_delay[i];
      end
    end
    channel_enable = en;
    repeat_count   = rep[RW-1:0];
    gap_cycles     = gap[GW-1:0];
    @(negedge pl_clk);
    t0 = cyc;

    // Repetition r begins (counter = 0) at r_cyc; channel i starts at
    // r_cyc+d_i+1, its done is seen lat later, pending clears one cycle
    // after that, and the exit takes effect the following cycle.
    nreps    = (rep == 0) ? 64 : rep;
    r_cyc    = t0 + 2;
    done_cyc = -1;
    for (int r = 0; r < nreps; r++) begin
      rep_start.push_back(r_cyc);
      for (int i = 0; i < NCH; i++) begin
        if (en[i]) begin
          s = r_cyc + model_delay[i] + 1;
          if (!exp_start.exists(s)) exp_start[s] = '0;
          exp_start[s] = exp_start[s] | (NCH'(1) << i);
        end
      end
      c_cyc = r_cyc + dmax + lat + 2;
      if (rep != 0 && r == nreps - 1) done_cyc = c_cyc + 1;
      r_cyc = c_cyc + 1 + gap;
    end

    abort_cyc = (abort_after >= 0) ? (t0 + 3 + dmin + abort_after) : -1;
    if (abort_cyc >= 0 && (done_cyc < 0 || abort_cyc < done_cyc)) begin
      done_cyc = -1;
      busy_end = abort_cyc + 1;
    end else begin
      busy_end = done_cyc + 1;
    end

    for (int i = 0; i < NCH; i++) due[i] = -1;

    for (int k = t0; k <= busy_end + 6; k++) begin
      if (k != t0) @(negedge pl_clk);
      trigger   = (k == t0) || (retrig && k >= t0 + 4 && k < t0 + 6);
      abort     = (k == abort_cyc);
      cfg_we    = (k == t0 + 3);
      cfg_addr  = 4'($urandom);
      cfg_delay = DW'($urandom);
      for (int i = 0; i < NCH; i++) chan_done[i] = (due[i] == k);
      if (noise) chan_done = chan_done | (NCH'($urandom) & ~en);

      exp_mask = '0;
      if (exp_start.exists(k) && (abort_cyc < 0 || k <= abort_cyc)) exp_mask = exp_start[k];
      check("chan_start", chan_start, exp_mask);
      check("busy", busy, (k >= t0 + 1) && (k < busy_end));
      check("seq_done", seq_done, k == done_cyc);
      if (k >= t0 + 1) check("timeout_err", timeout_err, 0);
      if (k >= t0 + 2 && k < busy_end) begin
        idx = 0;
        for (int j = 0; j < rep_start.size(); j++) if (rep_start[j] <= k) idx = j;
        check("repeat_index", repeat_index, idx & 16'hFFFF);
      end

      for (int i = 0; i < NCH; i++) if (chan_start[i]) due[i] = k + lat;
    end
    trigger   = 1'b0;
    abort     = 1'b0;
    cfg_we    = 1'b0;
    chan_done = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "global timeout");
  end

  initial begin
    rst            = 1'b1;
    cfg_we         = 1'b0;
    cfg_addr       = '0;
    cfg_delay      = '0;
    channel_enable = '0;
    repeat_count   = '0;
    gap_cycles     = '0;
    trigger        = 1'b0;
    abort          = 1'b0;
    chan_done      = '0;
    for (int i = 0; i < NCH; i++) model_delay[i] = 0;

    repeat (3) @(negedge pl_clk);
    check("rst_chan_start", chan_start, 0);
    check("rst_busy", busy, 0);
    check("rst_seq_done", seq_done, 0);
    check("rst_repeat_index", repeat_index, 0);
    check("rst_timeout_err", timeout_err, 0);
    rst = 1'b0;
    @(negedge pl_clk);

    // Table is all zero after reset: every enabled channel fires at T+3.
    run_seq(16'h0003, 1, 0, 2, -1, 0, 0);

    // Mixed delays {0,5,5,20}, single repetition.
    write_entry(0, 0);
    write_entry(1, 5);
    write_entry(2, 5);
    write_entry(3, 20);
    run_seq(16'h000F, 1, 0, 3, -1, 0, 0);

    // Three repetitions with a 10-cycle gap, done 4 cycles after each start.
    write_entry(0, 2);
    run_seq(16'h0001, 3, 10, 4, -1, 0, 0);

    // Abort 3 cycles after the start, before the done returns.
    run_seq(16'h0001, 1, 0, 8, 3, 0, 0);

    // Re-trigger while busy and done noise on disabled channels.
    program_random(25);
    run_seq(16'h00F0, 2, 2, 3, -1, 1, 1);

    // Empty enable mask: trigger edge must be ignored.
    channel_enable = '0;
    @(negedge pl_clk);
    trigger = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge pl_clk);
      check("en0_busy", busy, 0);
      check("en0_chan_start", chan_start, 0);
    end
    trigger = 1'b0;

    // Same table again: the write issued while busy must not have landed.
    run_seq(16'hFFFF, 1, 1, 2, -1, 0, 0);

    // Continuous mode, aborted after a few repetitions; gap of zero too.
    run_seq(16'h0300, 0, 3, 2, 120, 0, 0);
    run_seq(16'h0081, 0, 0, 1, 90, 1, 0);

    for (int n = 0; n < 16; n++) begin
      logic [NCH-1:0] en;
      if (n % 2 == 0) program_random(30);
      en = NCH'($urandom);
      if (en == '0) en = 16'h0001;
      run_seq(en, $urandom_range(1, 4), $urandom_range(0, 8), $urandom_range(1, 6),
              -1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

`ifdef SEQ_TIMEOUT_EN
    begin
      int t0;
      int fell;
      write_entry(0, 0);
      channel_enable = 16'h0001;
      repeat_count   = 16'd1;
      gap_cycles     = '0;
      @(negedge pl_clk);
      t0      = cyc;
      trigger = 1'b1;
      fell    = -1;
      for (int k = t0; k < t0 + 300 && fell < 0; k++) begin
        if (k != t0) @(negedge pl_clk);
        if (k == t0 + 1) trigger = 1'b0;
        if (k > t0 + 1 && !busy) fell = k;
      end
      trigger = 1'b0;
      // Fire at T+2, pending from T+3, TO watchdog cycles, IDLE next cycle.
      check("timeout_idle_cycle", fell, t0 + 3 + TO);
      check("timeout_err_set", timeout_err, 1);
      run_seq(16'h0001, 1, 0, 2, -1, 0, 0);
    end
`endif

    check("final_timeout_err", timeout_err, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
